// File: rtl/spi_pkg.sv
// Purpose: shared types and constants for the SPI master data path and its sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package spi_pkg;

  // Frame state of the shift engine.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  // Default frame length in bits.
  localparam int SPI_DATA_W = 8;

  // SPI mode 0. The sequencer uses these to generate sclk; the engine is built for them.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_shift_engine_edge_det.sv
// Purpose: registered rising/falling edge detector for one single-bit signal.
// Latency: rise/fall are combinational against a copy of d delayed by one clk.
// Backpressure: none; rise/fall are single-cycle strobes.
// Ports: clk, rst_n (async, active low), d (sampled signal),
//        rise / fall (one-cycle strobes). RST_VAL is the reset value of the copy.
module edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= d;
    end
  end

  assign rise = ~d_q & d;
  assign fall = d_q & ~d;

endmodule

// File: rtl/spi_shift_engine.sv
// Purpose: SPI mode-0 master data path: shifts tx words out MSB-first on mosi,
//          assembles miso bits into rx_data, and flags short frames.
// Latency: every response is one clk after the cs_in/sclk_in change causing it.
// Backpressure: none; rx_valid/frame_err are single-cycle pulses with no ready.
// Ports: clk, rst_n (async, active low); cs_in/sclk_in from the sequencer;
//        miso in, mosi out; tx_data/tx_load fill the tx buffer;
//        rx_data/rx_valid give the received word; frame_err, busy are status.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_in,
  input  logic              sclk_in,
  input  logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

  logic cs_rise, cs_fall;
  logic sclk_rise, sclk_fall;

  spi_state_t        state;
  logic [DATA_W-1:0] tx_buf;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [CNT_W-1:0]  bit_cnt;

  // cs copy resets high so a cs_in already low at reset release starts a frame.
  edge_det #(.RST_VAL(1'b1)) u_cs_det (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cs_in),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  edge_det #(.RST_VAL(1'b0)) u_sclk_det (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sclk_in),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_buf    <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      mosi      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      // The shift register is copied only at frame start, so a load here
      // during a frame only affects the next one.
      if (tx_load) begin
        tx_buf <= tx_data;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= ACTIVE;
            busy     <= 1'b1;
            tx_shift <= tx_buf;
            mosi     <= tx_buf[DATA_W-1];
            bit_cnt  <= '0;
            rx_shift <= '0;
          end
        end

        ACTIVE: begin
          // Frame end wins over any sclk edge seen in the same cycle.
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            mosi  <= 1'b0;
            if (bit_cnt == CNT_MAX) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (bit_cnt != CNT_MAX) begin
            // Once a full word is in, further edges are ignored and mosi holds.
            if (sclk_rise) begin
              rx_shift <= {rx_shift[DATA_W-2:0], miso};
              bit_cnt  <= bit_cnt + CNT_W'(1);
            end
            if (sclk_fall) begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              mosi     <= tx_shift[DATA_W-2];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
